dmem_loader: RTL and testbench
==============================

Name: dmem_loader

Overview:
- Upstream feeder for the data memory: receives a byte stream over a valid/ready handshake and assembles it into DATA_W-bit words.
- Writes each word sequentially into dmem through dmem's write port (a, wd, we).
- Replaces initial-block preloading of dataset images, e.g. node/edge-list words, so datasets load at run time.
- Asserts cpu_hold while loading, so the core does not use dmem until the image is complete.

Parameters:
- DATA_W, 32, word width; must be a multiple of 8; BPW = DATA_W/8 bytes per word.
- DEPTH, 65536, dmem depth in words.
- BASE_ADDR, 0, first dmem word address written.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load when idle or done.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts byte this cycle.
- mem_a  output  16  dmem word address (to dmem a).
- mem_wd  output  DATA_W  dmem write data (to dmem wd).
- mem_we  output  1  dmem write enable (to dmem we).
- cpu_hold  output  1  high while a load is in progress.
- done  output  1  high from load completion until next start.
- err  output  1  length rejected; held until next start.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; byte counter, word counter and length register cleared.
- States: IDLE, LEN_HI, LEN_LO, DATA, FLUSH, DONE.
- Byte transfer occurs only when in_valid and in_ready are both high on a rising clk edge.
- IDLE/DONE:
  - start=1 moves to LEN_HI; clears done and err; sets cpu_hold.
  - start is ignored in all other states.
- LEN_HI: accepted byte becomes LEN[15:8].
- LEN_LO: accepted byte becomes LEN[7:0].
  - Decision uses LEN_HI and this byte directly.
  - LEN=0: go to DONE; done=1 and cpu_hold=0 next cycle.
  - LEN > DEPTH-BASE_ADDR: go to DONE with err=1; no writes.
  - Otherwise: go to DATA.
- DATA:
  - Bytes are packed MSB first: byte 0 is word[DATA_W-1:DATA_W-8].
  - On acceptance of byte BPW-1, mem_we=1 in the next cycle, for exactly one cycle.
  - In that cycle mem_a = BASE_ADDR + word index and mem_wd = the assembled word.
  - in_ready stays high during the write cycle; back-to-back words sustain 1 byte/cycle with no bubble.
- Last word: after acceptance of the final byte of word LEN-1, state goes to FLUSH.
  - FLUSH issues the final write and deasserts in_ready.
  - Next cycle: DONE, done=1, cpu_hold=0.
- in_ready:
  - High in LEN_HI, LEN_LO, DATA.
  - Low in IDLE, FLUSH, DONE.
- mem_we: never asserted outside the write cycle. mem_a and mem_wd hold their last values when we=0.
- Address arithmetic:
  - 16-bit, no wrap; the length check guarantees mem_a ≤ DEPTH-1.
  - LEN=DEPTH-BASE_ADDR is legal and fills memory exactly.
- Stalls: in_valid low mid-word keeps the partial word and byte counter unchanged indefinitely.
- Reset mid-load: immediate abort; partial word discarded; words already written remain in dmem.
- A start pulse coincident with the cycle that enters DONE is ignored; it takes effect only once in DONE.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 00 07, followed by the 28 bytes of the words 070c0001, 00020003, 01020106, 02030205, 02060304, 03050405, 05060000, in_valid always 1.
  - Required: 7 we pulses on consecutive byte-4 boundaries, at a=0..6 with matching wd.
  - Required: done=1 and cpu_hold=0 two cycles after the last byte.
- Stalls: same image with in_valid toggling randomly (~50%) → identical writes and addresses; no extra we pulses.
- Zero length: start, bytes 00 00 → no we; done=1 one cycle after LEN_LO accept; in_ready=0 afterwards.
- Over-length: BASE_ADDR=0, DEPTH=16, LEN=0x0011 → err=1, done=1, no we. Then start with LEN=0x0010 → 16 writes, a=0..15, err=0.
- Reset mid-load: rst_n low after byte 2 of word 3 → outputs 0 asynchronously. After a new start with LEN=1 and word deadbeef → one write at a=BASE_ADDR, wd=deadbeef.
- Ignored start: pulse start during DATA → no restart; counters unaffected; load completes normally.

Source files
------------

// File: rtl/dmem_loader.sv
// dmem_loader: turns a length-prefixed byte stream into sequential dmem word writes while holding the CPU off.
module dmem_loader #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 65536,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    localparam int BPW = DATA_W / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [31:0]   MAX_LEN   = 32'(DEPTH - BASE_ADDR);
    localparam logic [15:0]   BASE      = 16'(BASE_ADDR);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_q, word_d;
    logic [CW-1:0]     byte_q, byte_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [15:0]       mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic              mem_we_q, mem_we_d;
    logic              err_q, err_d;
    logic              accept;
    logic [DATA_W+7:0] packed_w;

    assign in_ready = state_q inside {LEN_HI, LEN_LO, DATA};
    assign cpu_hold = state_q inside {LEN_HI, LEN_LO, DATA, FLUSH};
    assign done     = state_q == DONE;
    assign accept   = in_valid && in_ready;
    assign packed_w = {shift_q, in_data};
    assign mem_a    = mem_a_q;
    assign mem_wd   = mem_wd_q;
    assign mem_we   = mem_we_q;
    assign err      = err_q;

    // Next-state: length header, MSB-first word packing and a one-cycle write strobe per completed word.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        word_d   = word_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        mem_we_d = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LEN_HI;
                    err_d   = 1'b0;
                    word_d  = '0;
                    byte_d  = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data, len_q[7:0]};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d   = {len_q[15:8], in_data};
                    state_d = (len_d == 16'd0) ? DONE : (32'(len_d) > MAX_LEN) ? DONE : DATA;
                    err_d   = (len_d != 16'd0) && (32'(len_d) > MAX_LEN);
                end
            end
            DATA: begin
                if (accept) begin
                    shift_d = packed_w[DATA_W-1:0];
                    byte_d  = byte_q + 1'b1;
                    if (byte_q == LAST_BYTE) begin
                        byte_d   = '0;
                        word_d   = word_q + 16'd1;
                        mem_we_d = 1'b1;
                        mem_a_d  = BASE + word_q;
                        mem_wd_d = packed_w[DATA_W-1:0];
                        state_d  = (word_q == len_q - 16'd1) ? FLUSH : DATA;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any load and discards a partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            word_q   <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            word_q   <= word_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            mem_we_q <= mem_we_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: randomized self-checking bench comparing dmem writes against an expected image.
module tb_dmem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] img[$];
    logic [15:0] obs_a[$];
    logic [31:0] obs_d[$];
    int          obs_c[$];

    dmem_loader #(.DATA_W(32), .DEPTH(16), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between write strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_a.push_back(mem_a);
            obs_d.push_back(mem_wd);
            obs_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_d.delete();
        obs_c.delete();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_hold", cpu_hold, 1);
        check("start_rdy", in_ready, 1);
        check("start_done", done, 0);
        check("start_err", err, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int  guard;
        bit  r;
        guard = 0;
        if (stall) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            r = in_ready;
            @(posedge clk); #1;
            if (r) break;
            guard++;
            if (guard > 40) begin
                check("rdy_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic run_load(input logic [15:0] len, input bit stall, input int start_at);
        int nb;
        bit ok;
        int nexp;
        clear_obs();
        start_pulse();
        send_byte(len[15:8], stall);
        send_byte(len[7:0], stall);
        ok = (len != 16'd0) && (len <= 16'd16);
        if (!ok) begin
            in_valid = 1'b0;
            check("short_done", done, 1);
            check("short_err", err, (len != 16'd0));
            check("short_hold", cpu_hold, 0);
            check("short_rdy", in_ready, 0);
            @(posedge clk); #1;
            check("short_rdy2", in_ready, 0);
        end else begin
            nb = 0;
            for (int w = 0; w < int'(len); w++) begin
                for (int b = 3; b >= 0; b--) begin
                    if (nb == start_at) begin
                        in_valid = 1'b0;
                        start = 1'b1;
                        @(posedge clk); #1;
                        start = 1'b0;
                    end
                    send_byte(img[w][8*b +: 8], stall);
                    nb++;
                end
            end
            in_valid = 1'b0;
            check("flush_we", mem_we, 1);
            check("flush_rdy", in_ready, 0);
            check("flush_done", done, 0);
            check("flush_hold", cpu_hold, 1);
            @(posedge clk); #1;
            check("end_done", done, 1);
            check("end_hold", cpu_hold, 0);
            check("end_rdy", in_ready, 0);
            check("end_we", mem_we, 0);
            check("end_err", err, 0);
        end
        @(posedge clk); #1;
        nexp = ok ? int'(len) : 0;
        check("nwr", obs_a.size(), nexp);
        for (int i = 0; i < obs_a.size() && i < nexp; i++) begin
            check($sformatf("wr_a[%0d]", i), obs_a[i], i);
            check($sformatf("wr_d[%0d]", i), obs_d[i], img[i]);
            if (!stall && start_at < 0 && i > 0)
                check($sformatf("gap[%0d]", i), obs_c[i] - obs_c[i-1], 4);
        end
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom());
    endtask

    initial begin
        logic [15:0] l;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {in_ready, mem_we, cpu_hold, done, err, mem_a, mem_wd}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_hold", cpu_hold, 0);

        img = '{32'h070c0001, 32'h00020003, 32'h01020106, 32'h02030205,
                32'h02060304, 32'h03050405, 32'h05060000};
        run_load(16'd7, 1'b0, -1);
        run_load(16'd7, 1'b1, -1);
        run_load(16'd0, 1'b0, -1);
        run_load(16'h0011, 1'b0, -1);
        rand_img(16);
        run_load(16'h0010, 1'b0, -1);

        img = '{32'h070c0001, 32'h00020003, 32'h01020106, 32'h02030205,
                32'h02060304, 32'h03050405, 32'h05060000};
        run_load(16'd7, 1'b0, 10);

        for (int k = 0; k < 4; k++) begin
            l = 16'($urandom_range(16, 1));
            rand_img(int'(l));
            run_load(l, 1'b1, -1);
        end

        rand_img(5);
        clear_obs();
        start_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        for (int n = 0; n < 10; n++) send_byte(img[n/4][8*(3 - n%4) +: 8], 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_out", {in_ready, mem_we, cpu_hold, done, err, mem_a, mem_wd}, 64'd0);
        check("arst_nwr", obs_a.size(), 2);
        for (int i = 0; i < obs_a.size() && i < 2; i++) begin
            check("arst_a", obs_a[i], i);
            check("arst_d", obs_d[i], img[i]);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_hold", cpu_hold, 0);
        check("post_rst_done", done, 0);
        img = '{32'hdeadbeef};
        run_load(16'd1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
